// File: rtl/pu_rd_arbiter.sv
`default_nettype none
// pu_rd_arbiter: round-robin, burst-locked sharing of one buffer read stream among NUM_PU units.
// Rev 1.0 - initial release.
module pu_rd_arbiter #(
  parameter int NUM_PU = 4,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int ID_W   = $clog2(NUM_PU)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PU-1:0]       pu_rd_req,
  input  logic [NUM_PU*LEN_W-1:0] pu_rd_len,
  output logic [NUM_PU-1:0]       pu_rd_grant,
  output logic [NUM_PU-1:0]       pu_rd_data_v,
  output logic [DATA_W-1:0]       pu_rd_data,
  output logic                    pu_rd_last,
  output logic                    mem_rd_req,
  output logic [LEN_W-1:0]        mem_rd_len,
  input  logic                    mem_rd_ready,
  input  logic                    mem_rd_data_v,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic                    busy,
  output logic [ID_W-1:0]         owner,
  output logic                    stray_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     owner_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic [NUM_PU-1:0]   data_v_q;
  logic [DATA_W-1:0]   data_q;
  logic                last_q;
  logic                stray_q;

  logic                win_vld_d;
  logic [ID_W-1:0]     win_idx_d;
  logic [ID_W-1:0]     rr_next_d;
  logic [NUM_PU-1:0]   owner_oh;

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int i = NUM_PU - 1; i >= 0; i--) begin
      if (pu_rd_req[ID_W'((int'(rr_ptr_q) + i) % NUM_PU)]) begin
        win_vld_d = 1'b1;
        win_idx_d = ID_W'((int'(rr_ptr_q) + i) % NUM_PU);
      end
    end
  end

  assign rr_next_d = (owner_q == ID_W'(NUM_PU - 1)) ? '0 : owner_q + 1'b1;
  assign owner_oh  = NUM_PU'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      data_v_q   <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      data_v_q <= '0;
      last_q   <= 1'b0;
      if (mem_rd_data_v && (state_q != ST_DATA)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (win_vld_d) begin
            owner_q <= win_idx_d;
            len_q   <= pu_rd_len[win_idx_d*LEN_W +: LEN_W];
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_rd_ready) begin
            beat_cnt_q <= '0;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rd_data_v) begin
            data_v_q   <= owner_oh;
            data_q     <= mem_rd_data;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) begin
              last_q   <= 1'b1;
              rr_ptr_q <= rr_next_d;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant must coincide with the memory handshake, so it is decoded from state and ready.
  assign pu_rd_grant  = ((state_q == ST_CMD) && mem_rd_ready) ? owner_oh : '0;
  assign mem_rd_req   = (state_q == ST_CMD);
  assign mem_rd_len   = len_q;
  assign pu_rd_data_v = data_v_q;
  assign pu_rd_data   = data_q;
  assign pu_rd_last   = last_q;
  assign busy         = (state_q != ST_IDLE);
  assign owner        = owner_q;
  assign stray_err    = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_pu_rd_arbiter.sv
`default_nettype none
// tb_pu_rd_arbiter: vector table, directed corner sequences and random traffic against a transaction model.
// Rev 1.0 - initial release.
module tb_pu_rd_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req;
  logic [NP*LW-1:0] len_bus;
  logic            ready, mdv;
  logic [DW-1:0]   mdata;
  logic [NP-1:0]   grant, odv;
  logic [DW-1:0]   odata;
  logic            olast, mreq, busy, stray;
  logic [LW-1:0]   mlen;
  logic [IW-1:0]   owner;

  pu_rd_arbiter #(.NUM_PU(NP), .DATA_W(DW), .LEN_W(LW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .pu_rd_req(req), .pu_rd_len(len_bus),
    .pu_rd_grant(grant), .pu_rd_data_v(odv), .pu_rd_data(odata), .pu_rd_last(olast),
    .mem_rd_req(mreq), .mem_rd_len(mlen), .mem_rd_ready(ready),
    .mem_rd_data_v(mdv), .mem_rd_data(mdata),
    .busy(busy), .owner(owner), .stray_err(stray)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [NP-1:0] s_grant, s_dv;
  logic [DW-1:0] s_data;
  logic          s_last, s_mreq, s_busy, s_stray;
  logic [LW-1:0] s_mlen;
  logic [IW-1:0] s_owner;

  // Transaction-level reference: phase 0 idle, 1 command, 2 data.
  bit            m_en = 1'b0;
  int            m_phase, m_owner, m_ptr, m_left;
  logic [LW-1:0] m_len;
  logic [NP-1:0] m_dv;
  logic [DW-1:0] m_data;
  logic          m_last, m_stray;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NP-1:0] r, input int p);
    for (int k = 0; k < NP; k++) if (r[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  task automatic set_len(input int pu, input int v);
    len_bus[pu*LW +: LW] = LW'(v);
  endtask

  task automatic model_step();
    int w;
    chk("m_busy", s_busy, m_phase != 0);
    chk("m_grant", s_grant, (m_phase == 1 && ready) ? 64'(1 << m_owner) : 64'h0);
    chk("m_mem_req", s_mreq, m_phase == 1);
    if (m_phase == 1) chk("m_mem_len", s_mlen, m_len);
    chk("m_data_v", s_dv, m_dv);
    chk("m_last", s_last, m_last);
    if (m_dv != 0) chk("m_data", s_data, m_data);
    chk("m_owner", s_owner, m_owner);
    chk("m_stray", s_stray, m_stray);
    m_dv = '0;
    m_last = 1'b0;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_stray = 1'b0; m_len = '0;
    end else begin
      if (mdv && m_phase != 2) m_stray = 1'b1;
      case (m_phase)
        0: begin
          w = rr_pick(req, m_ptr);
          if (w >= 0) begin
            m_owner = w; m_len = len_bus[w*LW +: LW]; m_phase = 1;
          end
        end
        1: if (ready) begin m_left = int'(m_len) + 1; m_phase = 2; end
        default: if (mdv) begin
          m_dv = NP'(1 << m_owner);
          m_data = mdata;
          m_left--;
          if (m_left == 0) begin
            m_last = 1'b1; m_ptr = (m_owner + 1) % NP; m_phase = 0;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_grant = grant; s_dv = odv; s_data = odata; s_last = olast; s_mreq = mreq;
    s_mlen = mlen; s_busy = busy; s_owner = owner; s_stray = stray;
    if (m_en) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ready = 1'b0; mdv = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 300 && idx < 0; c++) begin
      ready = 1'b1; mdv = (m_phase == 2); mdata = {$urandom, $urandom};
      tick();
      for (int k = 0; k < NP; k++) if (s_grant[k]) idx = k;
      req = req & ~s_grant;
    end
    ready = 1'b0; mdv = 1'b0;
    if (idx < 0) chk("grant_timeout", 64'h1, 64'h0);
  endtask

  task automatic drain();
    for (int c = 0; c < 600 && m_phase != 0; c++) begin
      ready = 1'b1; mdv = (m_phase == 2); mdata = {$urandom, $urandom};
      tick();
      req = req & ~s_grant;
    end
    ready = 1'b0; mdv = 1'b0;
    tick();
  endtask

  task automatic run_burst(input int pu, input int len, output int nb, output int lidx);
    int g;
    nb = 0; lidx = 0;
    set_len(pu, len); req[pu] = 1'b1;
    wait_grant(g);
    chk("burst_grant_pu", 64'(g), 64'(pu));
    for (int c = 0; c < len + 40 && lidx == 0; c++) begin
      mdv = (m_phase == 2); mdata = {$urandom, $urandom};
      tick();
      if (s_dv[pu]) begin
        nb++;
        if (s_last) lidx = nb;
      end
    end
    mdv = 1'b0;
  endtask

  typedef struct {
    logic [NP-1:0] req;
    logic          ready, dv;
    logic [DW-1:0] data;
    logic          busy;
    logic [NP-1:0] grant;
    logic          mreq;
    logic [NP-1:0] odv;
    logic [DW-1:0] odata;
    logic          last;
  } vec_t;

  function automatic vec_t mk(logic [NP-1:0] r, logic rd, logic d, logic [DW-1:0] dat,
                              logic b, logic [NP-1:0] g, logic mr, logic [NP-1:0] ov,
                              logic [DW-1:0] od, logic l);
    vec_t v;
    v.req = r; v.ready = rd; v.dv = d; v.data = dat; v.busy = b; v.grant = g;
    v.mreq = mr; v.odv = ov; v.odata = od; v.last = l;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, lidx, g;
    int order[4];
    reset = 1'b1; req = '0; ready = 1'b0; mdv = 1'b0; mdata = '0; len_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    m_phase = 0; m_ptr = 0; m_owner = 0; m_len = '0; m_dv = '0; m_last = 1'b0;
    m_stray = 1'b0; m_data = '0; m_left = 0;
    m_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_state", {s_busy, s_grant, s_mreq, s_dv, s_last, s_owner, s_stray, s_mlen}, 64'h0);

    // Single burst (PU1, len 3) then command backpressure (PU2, ready low 5 cycles).
    len_bus = {NP{8'd3}};
    tbl[0]  = mk(4'b0010, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0000, 64'h0,  0);
    tbl[1]  = mk(4'b0010, 1, 0, 64'h0,  1, 4'b0010, 1, 4'b0000, 64'h0,  0);
    tbl[2]  = mk(4'b0000, 0, 1, 64'hA0, 1, 4'b0000, 0, 4'b0000, 64'h0,  0);
    tbl[3]  = mk(4'b0000, 0, 1, 64'hA1, 1, 4'b0000, 0, 4'b0010, 64'hA0, 0);
    tbl[4]  = mk(4'b0000, 0, 1, 64'hA2, 1, 4'b0000, 0, 4'b0010, 64'hA1, 0);
    tbl[5]  = mk(4'b0000, 0, 1, 64'hA3, 1, 4'b0000, 0, 4'b0010, 64'hA2, 0);
    tbl[6]  = mk(4'b0000, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0010, 64'hA3, 1);
    tbl[7]  = mk(4'b0000, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0000, 64'h0,  0);
    tbl[8]  = mk(4'b0100, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0000, 64'h0,  0);
    for (int i = 9; i <= 13; i++)
      tbl[i] = mk(4'b0100, 0, 0, 64'h0, 1, 4'b0000, 1, 4'b0000, 64'h0, 0);
    tbl[14] = mk(4'b0100, 1, 0, 64'h0,  1, 4'b0100, 1, 4'b0000, 64'h0,  0);
    tbl[15] = mk(4'b0000, 0, 1, 64'hB0, 1, 4'b0000, 0, 4'b0000, 64'h0,  0);
    tbl[16] = mk(4'b0000, 0, 1, 64'hB1, 1, 4'b0000, 0, 4'b0100, 64'hB0, 0);
    tbl[17] = mk(4'b0000, 0, 1, 64'hB2, 1, 4'b0000, 0, 4'b0100, 64'hB1, 0);
    tbl[18] = mk(4'b0000, 0, 1, 64'hB3, 1, 4'b0000, 0, 4'b0100, 64'hB2, 0);
    tbl[19] = mk(4'b0000, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0100, 64'hB3, 1);
    tbl[20] = mk(4'b0000, 0, 0, 64'h0,  0, 4'b0000, 0, 4'b0000, 64'h0,  0);
    for (int r = 0; r < 21; r++) begin
      req = tbl[r].req; ready = tbl[r].ready; mdv = tbl[r].dv; mdata = tbl[r].data;
      tick();
      chk($sformatf("tbl%0d_busy", r), s_busy, tbl[r].busy);
      chk($sformatf("tbl%0d_grant", r), s_grant, tbl[r].grant);
      chk($sformatf("tbl%0d_mreq", r), s_mreq, tbl[r].mreq);
      chk($sformatf("tbl%0d_dv", r), s_dv, tbl[r].odv);
      chk($sformatf("tbl%0d_last", r), s_last, tbl[r].last);
      if (tbl[r].odv != 0) chk($sformatf("tbl%0d_data", r), s_data, tbl[r].odata);
    end

    // Contention: PU0 and PU2 from pointer 0; PU0 and PU3 re-request during PU0's burst.
    do_reset();
    set_len(0, 1); set_len(2, 2); set_len(3, 0);
    req = 4'b0101;
    wait_grant(order[0]);
    req[0] = 1'b1; req[3] = 1'b1;
    for (int k = 1; k < 4; k++) wait_grant(order[k]);
    chk("t2_order0", 64'(order[0]), 64'd0);
    chk("t2_order1", 64'(order[1]), 64'd2);
    chk("t2_order2", 64'(order[2]), 64'd3);
    chk("t2_order3", 64'(order[3]), 64'd0);
    drain();

    // Length extremes.
    run_burst(3, 0, nb, lidx);
    chk("len0_beats", 64'(nb), 64'd1);
    chk("len0_last_idx", 64'(lidx), 64'd1);
    drain();
    run_burst(1, 255, nb, lidx);
    chk("len255_beats", 64'(nb), 64'd256);
    chk("len255_last_idx", 64'(lidx), 64'd256);
    drain();

    // Stray beat in idle is dropped and latched until reset.
    do_reset();
    mdv = 1'b1; mdata = 64'hDEAD;
    tick();
    mdv = 1'b0;
    tick();
    chk("stray_no_dv", s_dv, 4'b0000);
    chk("stray_set", s_stray, 1'b1);
    run_burst(2, 1, nb, lidx);
    drain();
    chk("stray_sticky", s_stray, 1'b1);
    do_reset();
    tick();
    chk("stray_cleared", s_stray, 1'b0);

    // Reset two beats into an 8-beat burst, then pointer must be back at 0.
    set_len(1, 7);
    req = 4'b0010;
    wait_grant(g);
    nb = 0;
    for (int c = 0; c < 50 && nb < 2; c++) begin
      mdv = (m_phase == 2); mdata = {$urandom, $urandom};
      tick();
      if (mdv) nb++;
    end
    mdv = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6_busy", s_busy, 1'b0);
      chk("t6_dv", s_dv, 4'b0000);
      chk("t6_last", s_last, 1'b0);
    end
    set_len(0, 0); set_len(3, 0);
    req = 4'b1001;
    wait_grant(g);
    chk("t6_ptr_reset_pick", 64'(g), 64'd0);
    wait_grant(g);
    chk("t6_pu3_pick", 64'(g), 64'd3);
    drain();

    // Random traffic with random backpressure, occasional strays and resets.
    for (int it = 0; it < 3000; it++) begin
      req = req & ~s_grant;
      for (int i = 0; i < NP; i++) begin
        if (!req[i] && ($urandom % 6 == 0)) begin
          req[i] = 1'b1;
          set_len(i, ($urandom % 10 == 0) ? int'($urandom % 48) : int'($urandom % 4));
        end
      end
      reset = ($urandom % 500 == 0);
      ready = !reset && ($urandom % 3 != 0);
      mdv   = ((m_phase == 2) && ($urandom % 4 != 0)) || ($urandom % 700 == 0);
      mdata = {$urandom, $urandom};
      tick();
    end
    reset = 1'b0;
    req = '0;
    drain();
    chk("final_idle", s_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
